iir_biquad_folded_mc: RTL
=========================

Name: iir_biquad_folded_mc

Overview:
Multi-channel, time-multiplexed second-order IIR section (direct form I) built around a single shared multiplier-accumulator, folded five ways (one product per cycle).
Generalises the fixed three-fold filter in four ways:
- data width, fraction bits and channel count are parameters;
- coefficients are runtime inputs;
- samples move through a valid/ready handshake;
- the output saturates.
Sits between the sample source and downstream decimation/analysis logic; one instance serves CH interleaved channels.

Parameters:
W, 20, data and coefficient width (two's complement)
F, 10, fraction bits of data and coefficients (Q(W-F).F)
CH, 4, number of channels with independent history
CHW, 2, channel index width (clog2 of CH, minimum 1)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
x  input  W  input sample, signed QF
in_ch  input  CHW  channel of x
in_valid  input  1  x/in_ch/coefficients valid
in_ready  output  1  block can accept a sample
b0, b1, b2  input  W each  feed-forward coefficients, signed QF
a1, a2  input  W each  feedback coefficients, signed QF (subtracted)
y  output  W  filtered sample, signed QF, saturated
y_ch  output  CHW  channel of y
out_valid  output  1  one-cycle strobe: y/y_ch/sat valid
sat  output  1  y was clamped (qualified by out_valid)

Behaviour:
- Function: y[n] = b0·x[n] + b1·x[n-1] + b2·x[n-2] − a1·y[n-1] − a2·y[n-2], per channel.
- Reset (rst high at a clock edge):
  - y=0, y_ch=0, out_valid=0, sat=0, in_ready=0 while rst is high;
  - all channel histories (x1, x2, y1, y2) cleared to 0;
  - FSM goes to IDLE; in_ready=1 in the first cycle after rst deasserts.
  - Reset mid-computation aborts the sample: no out_valid, histories cleared.
- FSM states: IDLE, MAC0..MAC4, DONE.
  - IDLE: in_ready=1. Acceptance happens on the edge where in_valid & in_ready. At that edge x, in_ch and all five coefficients are latched and the accumulator is cleared; next state MAC0.
  - MACk: in_ready=0. The accumulator adds one product per edge, in order: b0·x, b1·x1, b2·x2, −a1·y1, −a2·y2. MAC4→DONE.
  - DONE: round, saturate and register y, y_ch and sat; update the channel history (x2←x1, x1←x, y2←y1, y1←saturated y); set out_valid=1 for the next cycle; next state IDLE.
- Latency and throughput:
  - Accept at edge k → out_valid high in the cycle following edge k+6.
  - in_ready is high in that same cycle, so the earliest next accept is edge k+7. Throughput is 1 sample per 7 clocks.
- Held inputs: in_valid held high with in_ready low has no effect. Coefficient or x changes after acceptance do not affect the sample in flight.
- Arithmetic:
  - products are full 2W-bit signed; the accumulator is 2W+3 bits signed and never wraps;
  - rounding is half-up: add 2^(F−1), then arithmetic shift right by F;
  - saturate to [−2^(W−1), 2^(W−1)−1], with sat=1 when clamped.
- Out-of-range channel: in_ch ≥ CH is accepted (the handshake completes) but the sample is discarded. Return to IDLE after acceptance: no out_valid, no history change.
- Outputs: y/y_ch/sat hold their last value when out_valid=0. out_valid never lasts more than 1 cycle.
- Single multiplier only; no combinational path from in_valid to in_ready.

Test Plan:
- Passthrough: b0=1024, others 0; ch0 x=512 (0.5, i.e. 20'b00000_00000_10000_00000) → y=512, y_ch=0, sat=0; out_valid exactly 7 clocks after accept edge + one cycle wide.
- Recursion: b0=1024, a1=−512, others 0; ch1 constant x=512 for 4 samples → y=512, 768, 896, 960.
- Saturation/rounding:
  - b0=2048, x=524287 → y=524287, sat=1.
  - b0=512, x=1 → y=1.
  - b0=512, x=−1 → y=0.
- Channel isolation: recursion setup; interleave ch0 x=512 and ch2 x=−512 → ch0 gives 512, 768…; ch2 gives −512, −768…; no cross-talk. in_ch=3 with CH=3 → no out_valid.
- Handshake: in_valid held high continuously → accepts spaced exactly 7 clocks; coefficient change during MAC2 does not alter the in-flight result.
- Reset: assert rst during MAC3 → no out_valid, y=0; next sample x=512 with recursion setup → y=512 (history cleared).

Source files
------------

// File: rtl/iir_biquad_folded_mc.sv
// Multi-channel direct-form-I biquad, folded onto one multiplier (5 products per sample).
// A sample takes 7 clocks from acceptance to the output strobe.
module iir_biquad_folded_mc #(
  parameter int unsigned W   = 20,
  parameter int unsigned F   = 10,
  parameter int unsigned CH  = 4,
  parameter int unsigned CHW = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic signed [W-1:0]   x,
  input  logic [CHW-1:0]        in_ch,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic signed [W-1:0]   b0,
  input  logic signed [W-1:0]   b1,
  input  logic signed [W-1:0]   b2,
  input  logic signed [W-1:0]   a1,
  input  logic signed [W-1:0]   a2,
  output logic signed [W-1:0]   y,
  output logic [CHW-1:0]        y_ch,
  output logic                  out_valid,
  output logic                  sat
);

  localparam int unsigned PW = 2 * W;
  localparam int unsigned AW = 2 * W + 3;
  localparam logic signed [AW-1:0] MAXV = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};
  localparam logic signed [AW-1:0] RND  = {{(AW-1){1'b0}}, 1'b1} << (F - 1);
  localparam logic [CHW:0]         CH_L = (CHW+1)'(CH);

  typedef enum logic [2:0] {IDLE, MAC0, MAC1, MAC2, MAC3, MAC4, DONE} state_t;

  state_t state_q, state_d;

  logic signed [W-1:0]  x_r, b0_r, b1_r, b2_r, a1_r, a2_r;
  logic [CHW-1:0]       ch_r;
  logic signed [AW-1:0] acc;
  logic signed [W-1:0]  x1_h [CH];
  logic signed [W-1:0]  x2_h [CH];
  logic signed [W-1:0]  y1_h [CH];
  logic signed [W-1:0]  y2_h [CH];

  logic                 accept;
  logic                 ch_ok;
  logic signed [W-1:0]  coef_op, data_op;
  logic                 sub_op;
  logic signed [PW-1:0] prod;
  logic signed [AW-1:0] prod_ext;
  logic signed [AW-1:0] rnd_sum, shr;
  logic signed [W-1:0]  y_next;
  logic                 clamp;

  // Handshake decode: ready only in IDLE and never during reset.
  always_comb begin
    in_ready = (state_q == IDLE) && !rst;
    accept   = in_valid && in_ready;
    ch_ok    = {1'b0, in_ch} < CH_L;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; out-of-range channels are accepted and dropped in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && ch_ok) state_d = MAC0;
      MAC0:    state_d = MAC1;
      MAC1:    state_d = MAC2;
      MAC2:    state_d = MAC3;
      MAC3:    state_d = MAC4;
      MAC4:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand select for the shared multiplier; feedback terms are subtracted.
  always_comb begin
    coef_op = '0;
    data_op = '0;
    sub_op  = 1'b0;
    case (state_q)
      MAC0: begin coef_op = b0_r; data_op = x_r;        end
      MAC1: begin coef_op = b1_r; data_op = x1_h[ch_r]; end
      MAC2: begin coef_op = b2_r; data_op = x2_h[ch_r]; end
      MAC3: begin coef_op = a1_r; data_op = y1_h[ch_r]; sub_op = 1'b1; end
      MAC4: begin coef_op = a2_r; data_op = y2_h[ch_r]; sub_op = 1'b1; end
      default: ;
    endcase
    prod     = coef_op * data_op;
    prod_ext = $signed({{(AW-PW){prod[PW-1]}}, prod});
  end

  // Half-up rounding followed by saturation to the output width.
  always_comb begin
    rnd_sum = acc + RND;
    shr     = rnd_sum >>> F;
    clamp   = 1'b0;
    y_next  = W'(shr);
    if (shr > MAXV) begin
      y_next = W'(MAXV);
      clamp  = 1'b1;
    end else if (shr < MINV) begin
      y_next = W'(MINV);
      clamp  = 1'b1;
    end
  end

  // Sample capture, accumulation, output registers and channel history.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_r <= '0; b0_r <= '0; b1_r <= '0; b2_r <= '0; a1_r <= '0; a2_r <= '0;
      ch_r      <= '0;
      acc       <= '0;
      y         <= '0;
      y_ch      <= '0;
      sat       <= 1'b0;
      out_valid <= 1'b0;
      for (int i = 0; i < int'(CH); i++) begin
        x1_h[i] <= '0;
        x2_h[i] <= '0;
        y1_h[i] <= '0;
        y2_h[i] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            x_r  <= x;
            ch_r <= in_ch;
            b0_r <= b0; b1_r <= b1; b2_r <= b2; a1_r <= a1; a2_r <= a2;
            acc  <= '0;
          end
        end
        MAC0, MAC1, MAC2, MAC3, MAC4: begin
          acc <= sub_op ? (acc - prod_ext) : (acc + prod_ext);
        end
        DONE: begin
          y          <= y_next;
          y_ch       <= ch_r;
          sat        <= clamp;
          out_valid  <= 1'b1;
          x2_h[ch_r] <= x1_h[ch_r];
          x1_h[ch_r] <= x_r;
          y2_h[ch_r] <= y1_h[ch_r];
          y1_h[ch_r] <= y_next;
        end
        default: ;
      endcase
    end
  end

endmodule
